// File: rtl/edge_cache_pkg.sv
// Shared constants for the graph blocks: default widths, node limit,
// the "no edge" (infinity) weight and the edge-cache FSM state type.
package edge_cache_pkg;

  localparam int DEF_MAX_NODES   = 16;
  localparam int DEF_INDEX_WIDTH = 4;
  localparam int DEF_VALUE_WIDTH = 8;
  localparam int DEF_MADDR_WIDTH = 16;
  localparam int DEF_MDATA_WIDTH = 8;
  localparam int DEF_CACHE_LINES = 8;

  // Weight reported for a missing / out-of-range edge
  localparam logic [DEF_VALUE_WIDTH-1:0] INF_VALUE = {DEF_VALUE_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/edge_cache_store.sv
// Direct-mapped line storage for edge_cache: valid bit, tag and value per line.
// Ports:
//   clock, reset      - clock, asynchronous active-low reset (clears all lines)
//   inv_all_i         - synchronous invalidate of every line
//   wr_en_i/wr_line_i/wr_tag_i/wr_value_i - single write port (sets valid)
//   rd_line_i         - combinational read address
//   rd_valid_o/rd_tag_o/rd_value_o - contents of the addressed line
module edge_cache_store
  import edge_cache_pkg::*;
#(
  parameter int LINES       = DEF_CACHE_LINES,
  parameter int TAG_WIDTH   = 2 * DEF_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  localparam int LINE_WIDTH = $clog2(LINES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inv_all_i,
  input  logic                   wr_en_i,
  input  logic [LINE_WIDTH-1:0]  wr_line_i,
  input  logic [TAG_WIDTH-1:0]   wr_tag_i,
  input  logic [VALUE_WIDTH-1:0] wr_value_i,
  input  logic [LINE_WIDTH-1:0]  rd_line_i,
  output logic                   rd_valid_o,
  output logic [TAG_WIDTH-1:0]   rd_tag_o,
  output logic [VALUE_WIDTH-1:0] rd_value_o
);

  logic                   valid_q [LINES];
  logic [TAG_WIDTH-1:0]   tag_q   [LINES];
  logic [VALUE_WIDTH-1:0] value_q [LINES];

  // Line storage: reset/invalidate clear valid bits, write fills one line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= {TAG_WIDTH{1'b0}};
        value_q[i] <= {VALUE_WIDTH{1'b0}};
      end
    end else if (inv_all_i) begin
      for (int i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en_i) begin
      valid_q[wr_line_i] <= 1'b1;
      tag_q[wr_line_i]   <= wr_tag_i;
      value_q[wr_line_i] <= wr_value_i;
    end
  end

  assign rd_valid_o = valid_q[rd_line_i];
  assign rd_tag_o   = tag_q[rd_line_i];
  assign rd_value_o = value_q[rd_line_i];

endmodule

// File: rtl/edge_cache.sv
// Edge-weight cache for an adjacency matrix held in external memory.
// A query (from_node, to_node) is answered from a direct-mapped cache or,
// on a miss, fetched from base_address + from*N + to.
// Ports:
//   reset, clock          - asynchronous active-low reset, rising-edge clock
//   base_address          - address of edge (0,0)
//   number_of_nodes       - node count N
//   from_node, to_node    - query nodes, latched when query_enable is accepted
//   mem_addr/mem_read_enable/mem_data/mem_read_ready - memory read handshake
//   ready, edge_value     - one-cycle result strobe and held result
//   query_enable          - start a query (sampled in IDLE only)
module edge_cache
  import edge_cache_pkg::*;
#(
  parameter int MAX_NODES   = DEF_MAX_NODES,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int MADDR_WIDTH = DEF_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEF_MDATA_WIDTH,
  parameter int CACHE_LINES = DEF_CACHE_LINES
) (
  input  logic                   reset,
  input  logic                   clock,
  input  logic [MADDR_WIDTH-1:0] base_address,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [INDEX_WIDTH-1:0] from_node,
  input  logic [INDEX_WIDTH-1:0] to_node,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  input  logic [MDATA_WIDTH-1:0] mem_data,
  output logic                   mem_read_enable,
  input  logic                   mem_read_ready,
  output logic                   ready,
  output logic [VALUE_WIDTH-1:0] edge_value,
  input  logic                   query_enable
);

  localparam int LINE_W = $clog2(CACHE_LINES);
  localparam int LIN_W  = 2 * INDEX_WIDTH;

  state_t                 state_q, state_d;
  logic [MADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                   mem_read_enable_q, mem_read_enable_d;
  logic                   ready_q, ready_d;
  logic [VALUE_WIDTH-1:0] edge_value_q, edge_value_d;
  logic [MADDR_WIDTH-1:0] base_q, base_d;
  logic [INDEX_WIDTH-1:0] nodes_q, nodes_d;
  logic [INDEX_WIDTH-1:0] from_q, from_d;
  logic [INDEX_WIDTH-1:0] to_q, to_d;
  logic                   pend_q, pend_d;
  logic [LIN_W-1:0]       fetch_lin_q, fetch_lin_d;

  logic                   cfg_chg_s, lk_go_s, lk_oor_s, lk_hit_s;
  logic [INDEX_WIDTH-1:0] lk_from_s, lk_to_s;
  logic [LIN_W-1:0]       lk_lin_s;
  logic [MADDR_WIDTH-1:0] lk_addr_s;
  logic                   inv_all_s, wr_en_s;
  logic                   rd_valid_s;
  logic [LIN_W-1:0]       rd_tag_s;
  logic [VALUE_WIDTH-1:0] rd_value_s;

  // A configuration change flushes the cache and defers the lookup of a
  // query accepted in the same cycle by one cycle (pend_q). The deferred
  // lookup then uses the latched query, so later input changes are harmless.
  assign cfg_chg_s = (base_address != base_q) || (number_of_nodes != nodes_q);
  assign lk_from_s = pend_q ? from_q : from_node;
  assign lk_to_s   = pend_q ? to_q   : to_node;
  assign lk_go_s   = (state_q == ST_IDLE) && !cfg_chg_s && (pend_q || query_enable);
  assign lk_oor_s  = (lk_from_s >= nodes_q) || (lk_to_s >= nodes_q) ||
                     (32'(lk_from_s) >= 32'(MAX_NODES)) || (32'(lk_to_s) >= 32'(MAX_NODES));
  assign lk_lin_s  = LIN_W'(lk_from_s) * LIN_W'(nodes_q) + LIN_W'(lk_to_s);
  assign lk_addr_s = base_q + MADDR_WIDTH'(lk_lin_s);
  assign lk_hit_s  = rd_valid_s && (rd_tag_s == lk_lin_s);

  edge_cache_store #(
    .LINES      (CACHE_LINES),
    .TAG_WIDTH  (LIN_W),
    .VALUE_WIDTH(VALUE_WIDTH)
  ) u_store (
    .clock      (clock),
    .reset      (reset),
    .inv_all_i  (inv_all_s),
    .wr_en_i    (wr_en_s),
    .wr_line_i  (fetch_lin_q[LINE_W-1:0]),
    .wr_tag_i   (fetch_lin_q),
    .wr_value_i (mem_data[VALUE_WIDTH-1:0]),
    .rd_line_i  (lk_lin_s[LINE_W-1:0]),
    .rd_valid_o (rd_valid_s),
    .rd_tag_o   (rd_tag_s),
    .rd_value_o (rd_value_s)
  );

  // State and output registers; reset aborts any fetch in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      mem_addr_q        <= {MADDR_WIDTH{1'b0}};
      mem_read_enable_q <= 1'b0;
      ready_q           <= 1'b0;
      edge_value_q      <= {VALUE_WIDTH{1'b0}};
      base_q            <= {MADDR_WIDTH{1'b0}};
      nodes_q           <= {INDEX_WIDTH{1'b0}};
      from_q            <= {INDEX_WIDTH{1'b0}};
      to_q              <= {INDEX_WIDTH{1'b0}};
      pend_q            <= 1'b0;
      fetch_lin_q       <= {LIN_W{1'b0}};
    end else begin
      state_q           <= state_d;
      mem_addr_q        <= mem_addr_d;
      mem_read_enable_q <= mem_read_enable_d;
      ready_q           <= ready_d;
      edge_value_q      <= edge_value_d;
      base_q            <= base_d;
      nodes_q           <= nodes_d;
      from_q            <= from_d;
      to_q              <= to_d;
      pend_q            <= pend_d;
      fetch_lin_q       <= fetch_lin_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (lk_go_s && !lk_oor_s && !lk_hit_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (mem_read_ready) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output, cache-control and latch next values per state
  always_comb begin
    mem_addr_d        = mem_addr_q;
    mem_read_enable_d = mem_read_enable_q;
    ready_d           = 1'b0;
    edge_value_d      = edge_value_q;
    base_d            = base_q;
    nodes_d           = nodes_q;
    from_d            = from_q;
    to_d              = to_q;
    pend_d            = pend_q;
    fetch_lin_d       = fetch_lin_q;
    inv_all_s         = 1'b0;
    wr_en_s           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_chg_s) begin
          inv_all_s = 1'b1;
          base_d    = base_address;
          nodes_d   = number_of_nodes;
          pend_d    = pend_q | query_enable;
          if (query_enable && !pend_q) begin
            from_d = from_node;
            to_d   = to_node;
          end else begin
            from_d = from_q;
          end
        end else if (lk_go_s) begin
          pend_d = 1'b0;
          if (lk_oor_s) begin
            ready_d      = 1'b1;
            edge_value_d = {VALUE_WIDTH{1'b1}};
          end else if (lk_hit_s) begin
            ready_d      = 1'b1;
            edge_value_d = rd_value_s;
          end else begin
            mem_read_enable_d = 1'b1;
            mem_addr_d        = lk_addr_s;
            fetch_lin_d       = lk_lin_s;
          end
        end else begin
          pend_d = pend_q;
        end
      end
      ST_FETCH: begin
        if (mem_read_ready) begin
          wr_en_s           = 1'b1;
          mem_read_enable_d = 1'b0;
          edge_value_d      = mem_data[VALUE_WIDTH-1:0];
          ready_d           = 1'b1;
        end else begin
          mem_read_enable_d = 1'b1;
        end
      end
      ST_DONE: ready_d = 1'b0;
      default: mem_read_enable_d = 1'b0;
    endcase
  end

  assign mem_addr        = mem_addr_q;
  assign mem_read_enable = mem_read_enable_q;
  assign ready           = ready_q;
  assign edge_value      = edge_value_q;

endmodule

// File: tb/tb_edge_cache.sv
// Self-checking bench for edge_cache: directed scenarios plus randomized
// queries checked against a line/tag model and a memory image.
module tb_edge_cache;

  logic        reset, clock;
  logic [15:0] base_address;
  logic [3:0]  number_of_nodes, from_node, to_node;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_read_enable, mem_read_ready, ready;
  logic [7:0]  edge_value;
  logic        query_enable;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:65535];
  int          model_tag [int];
  logic [15:0] m_base;
  logic [3:0]  m_n;
  bit          noise = 1'b0;

  // results of the last query
  logic [7:0]  q_val, q_val_after;
  bit          q_rd, q_timeout, q_addr_moved, q_double;
  logic [15:0] q_addr;
  int          q_lat;

  edge_cache dut (
    .reset          (reset),
    .clock          (clock),
    .base_address   (base_address),
    .number_of_nodes(number_of_nodes),
    .from_node      (from_node),
    .to_node        (to_node),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_read_enable(mem_read_enable),
    .mem_read_ready (mem_read_ready),
    .ready          (ready),
    .edge_value     (edge_value),
    .query_enable   (query_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one query at a negedge, act as memory, return at a negedge.
  task automatic do_query(input logic [3:0] f, input logic [3:0] t, input int delay);
    int  cnt;
    int  n;
    bit  got;
    q_rd = 1'b0; q_addr = 16'd0; q_lat = 0; q_timeout = 1'b0;
    q_addr_moved = 1'b0; q_double = 1'b0; q_val = 8'd0; q_val_after = 8'd0;
    from_node = f; to_node = t; query_enable = 1'b1;
    @(negedge clock);
    query_enable = 1'b0;
    from_node = 4'($urandom);
    to_node   = 4'($urandom);
    cnt = 0; got = 1'b0; n = 1;
    while (!got && n <= 60) begin
      mem_read_ready = 1'b0;
      if (ready === 1'b1) begin
        got = 1'b1; q_lat = n; q_val = edge_value;
      end else begin
        if (mem_read_enable === 1'b1) begin
          if (!q_rd) begin
            q_rd = 1'b1; q_addr = mem_addr;
          end else if (mem_addr !== q_addr) begin
            q_addr_moved = 1'b1;
          end
          cnt++;
          if (cnt == delay) begin
            mem_read_ready = 1'b1;
            mem_data = mem[mem_addr];
          end
        end else if (noise) begin
          mem_read_ready = 1'($urandom);
          mem_data = 8'($urandom);
        end
        @(negedge clock);
        n++;
      end
    end
    if (!got) begin
      q_timeout = 1'b1;
    end else begin
      @(negedge clock);
      if (ready !== 1'b0) q_double = 1'b1;
      q_val_after = edge_value;
    end
    mem_read_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; query_enable = 1'b0; mem_read_ready = 1'b0; mem_data = 8'd0;
    base_address = 16'd0; number_of_nodes = 4'd0; from_node = 4'd0; to_node = 4'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (mem_read_enable !== 1'b0 || ready !== 1'b0 || edge_value !== 8'd0 || mem_addr !== 16'd0) begin
        errors++;
        $display("FAIL reset_outputs: mre=%b ready=%b value=%h addr=%h, required all zero",
                 mem_read_enable, ready, edge_value, mem_addr);
      end
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic_miss();
    base_address = 16'd0; number_of_nodes = 4'd10; mem[23] = 8'd7;
    do_query(4'd2, 4'd3, 3);
    checks++;
    if (q_timeout || !q_rd || q_addr !== 16'd23 || q_addr_moved) begin
      errors++;
      $display("FAIL basic_fetch: timeout=%0d read=%0d addr=%0d moved=%0d, required one read at 23",
               q_timeout, q_rd, q_addr, q_addr_moved);
    end
    checks++;
    if (q_val !== 8'd7 || q_val_after !== 8'd7 || q_double) begin
      errors++;
      $display("FAIL basic_value: value=%0d held=%0d double=%0d, required 7 single pulse",
               q_val, q_val_after, q_double);
    end
  endtask

  task automatic test_hit();
    do_query(4'd2, 4'd3, 3);
    checks++;
    if (q_timeout || q_rd || q_lat != 1 || q_val !== 8'd7 || q_double) begin
      errors++;
      $display("FAIL hit_repeat: read=%0d latency=%0d value=%0d double=%0d, required no read, latency 1, 7",
               q_rd, q_lat, q_val, q_double);
    end
  endtask

  task automatic test_conflict();
    mem[31] = 8'd5;
    do_query(4'd3, 4'd1, 2);
    checks++;
    if (q_timeout || !q_rd || q_addr !== 16'd31 || q_val !== 8'd5) begin
      errors++;
      $display("FAIL conflict_fill: read=%0d addr=%0d value=%0d, required read at 31 value 5",
               q_rd, q_addr, q_val);
    end
    do_query(4'd2, 4'd3, 1);
    checks++;
    if (q_timeout || !q_rd || q_addr !== 16'd23 || q_val !== 8'd7) begin
      errors++;
      $display("FAIL conflict_evict: read=%0d addr=%0d value=%0d, required read at 23 value 7",
               q_rd, q_addr, q_val);
    end
  endtask

  task automatic test_out_of_range();
    do_query(4'd10, 4'd0, 1);
    checks++;
    if (q_timeout || q_rd || q_lat != 1 || q_val !== 8'hFF || q_val_after !== 8'hFF) begin
      errors++;
      $display("FAIL oor_from: read=%0d latency=%0d value=%h, required no read, latency 1, ff",
               q_rd, q_lat, q_val);
    end
    do_query(4'd0, 4'd15, 1);
    checks++;
    if (q_timeout || q_rd || q_lat != 1 || q_val !== 8'hFF) begin
      errors++;
      $display("FAIL oor_to: read=%0d latency=%0d value=%h, required no read, latency 1, ff",
               q_rd, q_lat, q_val);
    end
  endtask

  task automatic test_flush();
    number_of_nodes = 4'd11;
    do_query(4'd12, 4'd0, 1);
    checks++;
    if (q_timeout || q_rd || q_lat != 2 || q_val !== 8'hFF) begin
      errors++;
      $display("FAIL flush_latency: read=%0d latency=%0d value=%h, required no read, latency 2, ff",
               q_rd, q_lat, q_val);
    end
    number_of_nodes = 4'd10;
    do_query(4'd2, 4'd3, 1);
    checks++;
    if (q_timeout || !q_rd || q_addr !== 16'd23 || q_val !== 8'd7) begin
      errors++;
      $display("FAIL flush_invalidate: read=%0d addr=%0d value=%0d, required read at 23 value 7",
               q_rd, q_addr, q_val);
    end
    m_base = 16'd0; m_n = 4'd10;
  endtask

  task automatic test_random();
    logic [15:0] nb, addr;
    logic [3:0]  nn, f, t;
    logic [7:0]  exp_val;
    bit          chg, oor, exp_hit, exp_rd;
    int          lin, line, delay;
    noise = 1'b1;
    model_tag.delete();
    nb = m_base; nn = m_n;
    for (int i = 0; i < 80; i++) begin
      if (i == 0 || $urandom_range(0, 9) == 0) begin
        nb = 16'($urandom);
        nn = 4'($urandom_range(1, 15));
      end
      chg = (nb != m_base) || (nn != m_n);
      if (chg) model_tag.delete();
      m_base = nb; m_n = nn;
      base_address = nb; number_of_nodes = nn;
      f = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      t = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      delay = $urandom_range(1, 4);
      oor  = (f >= nn) || (t >= nn);
      lin  = int'(f) * int'(nn) + int'(t);
      line = lin % 8;
      addr = 16'(int'(nb) + lin);
      exp_hit = !oor && model_tag.exists(line) && (model_tag[line] == lin);
      exp_rd  = !oor && !exp_hit;
      exp_val = oor ? 8'hFF : mem[addr];
      do_query(f, t, delay);
      checks++;
      if (q_timeout || q_double || q_val !== exp_val || q_val_after !== exp_val) begin
        errors++;
        $display("FAIL rand_value[%0d] (%0d,%0d) N=%0d: value=%h held=%h timeout=%0d double=%0d, required %h",
                 i, f, t, nn, q_val, q_val_after, q_timeout, q_double, exp_val);
      end
      checks++;
      if (q_rd != exp_rd || (exp_rd && (q_addr !== addr || q_addr_moved))) begin
        errors++;
        $display("FAIL rand_access[%0d] (%0d,%0d) N=%0d: read=%0d addr=%h moved=%0d, required read=%0d addr=%h",
                 i, f, t, nn, q_rd, q_addr, q_addr_moved, exp_rd, addr);
      end
      if (!exp_rd) begin
        checks++;
        if (q_lat != (chg ? 2 : 1)) begin
          errors++;
          $display("FAIL rand_latency[%0d]: latency=%0d, required %0d", i, q_lat, chg ? 2 : 1);
        end
      end
      if (exp_rd) model_tag[line] = lin;
    end
    noise = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    bit saw;
    base_address = 16'd100; number_of_nodes = 4'd10; mem[123] = 8'd42;
    do_query(4'd2, 4'd3, 2);
    checks++;
    if (q_timeout || !q_rd || q_addr !== 16'd123 || q_val !== 8'd42) begin
      errors++;
      $display("FAIL base_change: read=%0d addr=%0d value=%0d, required read at 123 value 42",
               q_rd, q_addr, q_val);
    end
    from_node = 4'd4; to_node = 4'd5; query_enable = 1'b1;
    @(negedge clock);
    query_enable = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      if (mem_read_enable === 1'b1) saw = 1'b1;
      else @(negedge clock);
    end
    checks++;
    if (!saw || mem_addr !== 16'd145) begin
      errors++;
      $display("FAIL midfetch_start: read=%0d addr=%0d, required read at 145", saw, mem_addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_read_enable !== 1'b0 || ready !== 1'b0 || mem_addr !== 16'd0 || edge_value !== 8'd0) begin
      errors++;
      $display("FAIL midfetch_abort: mre=%b ready=%b addr=%h value=%h, required all zero",
               mem_read_enable, ready, mem_addr, edge_value);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (ready !== 1'b0 || mem_read_enable !== 1'b0) begin
        errors++;
        $display("FAIL midfetch_quiet: ready=%b mre=%b, required 0", ready, mem_read_enable);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    do_query(4'd4, 4'd5, 1);
    checks++;
    if (q_timeout || !q_rd || q_addr !== 16'd145 || q_val !== mem[145]) begin
      errors++;
      $display("FAIL midfetch_nofill: read=%0d addr=%0d value=%h, required read at 145 value %h",
               q_rd, q_addr, q_val, mem[145]);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic_miss();
    test_hit();
    test_conflict();
    test_out_of_range();
    test_flush();
    test_random();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_cache.md
EDGE_CACHE -- requirements
Module: edge_cache

Interface
REQ-001 SHALL have parameter MAX_NODES, default 16, maximum graph node count.
REQ-002 SHALL have parameter INDEX_WIDTH, default 4, node index width.
REQ-003 SHALL have parameter VALUE_WIDTH, default 8, edge weight width.
REQ-004 SHALL have parameter MADDR_WIDTH, default 16, memory address width.
REQ-005 SHALL have parameter MDATA_WIDTH, default 8, memory data width (>= VALUE_WIDTH).
REQ-006 SHALL have parameter CACHE_LINES, default 8, direct-mapped entry count (power of two).
REQ-007 Ports, in this positional order:
- reset, input, 1, asynchronous active-low reset.
- clock, input, 1, single clock; all logic on rising edge.
- base_address, input, MADDR_WIDTH, address of edge (0,0).
- number_of_nodes, input, INDEX_WIDTH, node count N.
- from_node, input, INDEX_WIDTH, query source node.
- to_node, input, INDEX_WIDTH, query destination node.
- mem_addr, output, MADDR_WIDTH, memory read address.
- mem_data, input, MDATA_WIDTH, memory read data.
- mem_read_enable, output, 1, memory read request.
- mem_read_ready, input, 1, memory data valid.
- ready, output, 1, one-cycle result strobe.
- edge_value, output, VALUE_WIDTH, result weight.
- query_enable, input, 1, start query (last port).
REQ-008 One clock; reset is asynchronous and active-low, ports named clock and reset.

Function
REQ-009 Edge address SHALL be base_address + from_node*number_of_nodes + to_node, computed modulo 2^MADDR_WIDTH; linear index = from_node*number_of_nodes + to_node.
REQ-010 Cache line SHALL be selected by linear index low log2(CACHE_LINES) bits; tag = full linear index; each line holds valid bit, tag, VALUE_WIDTH value.
REQ-011 FSM states IDLE, FETCH, DONE; query_enable sampled only in IDLE; ignored in other states.
REQ-012 IDLE, query_enable=1, hit: ready=1 and edge_value=cached value in the next cycle (latency 1); state stays IDLE-equivalent, no memory access.
REQ-013 IDLE, query_enable=1, miss: enter FETCH; next cycle mem_read_enable=1, mem_addr=edge address, both held stable until mem_read_ready sampled 1.
REQ-014 FETCH, mem_read_ready=1: capture mem_data[VALUE_WIDTH-1:0], fill line (valid=1), deassert mem_read_enable next cycle, enter DONE.
REQ-015 DONE: ready=1 for exactly one cycle with fetched value, return to IDLE; new query accepted in cycle after ready.
REQ-016 from_node >= number_of_nodes or to_node >= number_of_nodes: no memory access, ready pulse after 1 cycle, edge_value = all ones (infinity).
REQ-017 edge_value SHALL hold last result until next result; ready is never high two consecutive cycles for one query.
REQ-018 Query inputs SHALL be latched at acceptance; later changes do not affect the in-flight query.
REQ-019 Change of base_address or number_of_nodes versus latched copies, detected in IDLE, SHALL invalidate all lines before the next lookup (one-cycle penalty permitted, ready latency then +1).
REQ-020 mem_read_ready while not in FETCH SHALL be ignored.

Reset
REQ-021 reset=0 SHALL immediately force: state IDLE, all valid bits 0, mem_read_enable=0, mem_addr=0, ready=0, edge_value=0, latched config = 0.
REQ-022 Reset during FETCH SHALL abort the read; no line filled, no ready pulse.

Structure
REQ-023 Default widths, MAX_NODES and infinity value SHALL live in the shared constants package/include used by the other graph blocks.
REQ-024 Tag/valid/value storage SHALL be one sub-module edge_cache_store (read port combinational, one write port, synchronous invalidate-all).

Verification
REQ-025 Reset held low 2 cycles -> all outputs 0, mem_read_enable=0 throughout.
REQ-026 base=0, N=10, query (2,3), memory returns 7 after 3 cycles -> mem_addr=23, single ready pulse, edge_value=7.
REQ-027 Repeat query (2,3) -> ready 1 cycle after query_enable, mem_read_enable stays 0, edge_value=7.
REQ-028 Query (3,1) (index 31, same line as 23), data 5 -> miss, mem_addr=31, edge_value=5; then (2,3) misses again at mem_addr=23.
REQ-029 Query (10,0) with N=10 -> no memory read, ready after 1 cycle, edge_value=8'hFF.
REQ-030 base changed to 100 then query (2,3) -> miss, mem_addr=123; reset asserted mid-fetch -> no ready, mem_read_enable drops immediately.
